// File: rtl/load_store_unit_if.sv
// Execute-stage request/response and data-memory bus for the load/store unit.
// master = the load/store unit, slave = execute stage plus data memory.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_r_enable;
  logic              mem_w_enable;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_r_enable, mem_w_enable, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_r_enable, mem_w_enable, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time against a word-wide, registered-read memory.
// Sub-word loads are lane-extracted and extended; sub-word stores are read-modify-write.
module load_store_unit #(
  parameter int ADDR_W          = 32,
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  state_t            state, state_nxt;
  logic [1:0]        lo_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [15:0]       wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_err_q;

  logic [1:0]  sz;
  logic        f3_ok, misal, acc_err, acc_sw;
  logic [1:0]  acc_lo;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;
  logic [31:0] st_word;

  assign sz = bus.req_funct3[1:0];

  // Request decode only feeds registers; outputs never see req_* directly.
  always_comb begin
    f3_ok  = bus.req_we ? (!bus.req_funct3[2] && sz != 2'b11)
                        : !(bus.req_funct3 inside {3'b011, 3'b110, 3'b111});
    misal  = (sz == 2'b01 && bus.req_addr[0]) ||
             (sz == 2'b10 && bus.req_addr[1:0] != 2'b00);
    acc_err = !f3_ok || (ERR_ON_MISALIGN && misal);
    acc_sw  = bus.req_we && sz == 2'b10;
    acc_lo  = bus.req_addr[1:0];
    if (!ERR_ON_MISALIGN) begin
      if (sz == 2'b01) acc_lo[0] = 1'b0;
      if (sz == 2'b10) acc_lo    = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.req_valid) state_nxt = acc_err ? RESP : (acc_sw ? WR : RD);
      RD:   state_nxt = CAP;
      CAP:  state_nxt = we_q ? WR : RESP;
      WR:   state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Load lane extraction; f3_q[2] selects zero extension.
  always_comb begin
    ld_b = bus.mem_rdata[{lo_q, 3'b000} +: 8];
    ld_h = lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    unique case (f3_q[1:0])
      2'b00:   ld_data = {{24{ld_b[7] & ~f3_q[2]}}, ld_b};
      2'b01:   ld_data = {{16{ld_h[15] & ~f3_q[2]}}, ld_h};
      default: ld_data = bus.mem_rdata;
    endcase
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    localparam logic [1:0] LANE = 2'(k);
    logic hit;
    assign hit = (f3_q[1:0] == 2'b00) ? (lo_q == LANE) : (lo_q[1] == LANE[1]);
    assign st_word[8*k +: 8] = !hit       ? bus.mem_rdata[8*k +: 8] :
                               !f3_q[0]   ? wdata_q[7:0] :
                               LANE[0]    ? wdata_q[15:8] : wdata_q[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q         <= '0;
      we_q         <= 1'b0;
      f3_q         <= '0;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        lo_q         <= acc_lo;
        we_q         <= bus.req_we;
        f3_q         <= bus.req_funct3;
        wdata_q      <= bus.req_wdata[15:0];
        resp_err_q   <= acc_err;
        resp_rdata_q <= '0;
        // mem_addr only moves for accesses that will strobe the memory.
        if (!acc_err) mem_addr_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
        if (!acc_err && acc_sw) mem_wdata_q <= bus.req_wdata;
      end
      if (state == CAP) begin
        if (we_q) mem_wdata_q  <= st_word;
        else      resp_rdata_q <= ld_data;
      end
    end
  end

  assign bus.req_ready    = (state == IDLE);
  assign bus.mem_r_enable = (state == RD);
  assign bus.mem_w_enable = (state == WR);
  assign bus.resp_valid   = (state == RESP);
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.resp_rdata   = resp_rdata_q;
  assign bus.resp_err     = resp_err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: scoreboard of expected responses and
// strobe timing, checked by an independent monitor against a word memory model.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_done = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(32)) bus();

  load_store_unit #(.ADDR_W(32), .ERR_ON_MISALIGN(1'b1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
    int          rd_off;
    int          wr_off;
    logic [31:0] maddr;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [31:0] mem [256];

  // Word memory with registered read; preloaded until init_done.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h40] <= 32'h80FF7F01;
    end else begin
      if (bus.mem_r_enable) bus.mem_rdata <= mem[bus.mem_addr[9:2]];
      if (bus.mem_w_enable) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  int rd_n = 0, wr_n = 0, rd_at = 0, wr_at = 0;
  logic [31:0] rd_addr, wr_addr;
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_n = 0;
      wr_n = 0;
    end else begin
      if (bus.mem_r_enable || bus.mem_w_enable)
        chk("strobe_overlap", {31'b0, bus.mem_r_enable & bus.mem_w_enable}, 32'h0);
      if (bus.mem_r_enable) begin rd_n++; rd_at = cyc; rd_addr = bus.mem_addr; end
      if (bus.mem_w_enable) begin wr_n++; wr_at = cyc; wr_addr = bus.mem_addr; end
      if (bus.resp_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp rdata=%h err=%b (cycle %0d)", bus.resp_rdata, bus.resp_err, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_rdata", bus.resp_rdata, e.rdata);
          chk("resp_err", {31'b0, bus.resp_err}, {31'b0, e.err});
          chk("resp_cycle", cyc, e.acc + e.lat);
          chk("rd_count", rd_n, (e.rd_off >= 0) ? 1 : 0);
          chk("wr_count", wr_n, (e.wr_off >= 0) ? 1 : 0);
          if (e.rd_off >= 0 && rd_n > 0) begin
            chk("rd_cycle", rd_at, e.acc + e.rd_off);
            chk("rd_addr", rd_addr, e.maddr);
          end
          if (e.wr_off >= 0 && wr_n > 0) begin
            chk("wr_cycle", wr_at, e.acc + e.wr_off);
            chk("wr_addr", wr_addr, e.maddr);
          end
        end
        rd_n = 0;
        wr_n = 0;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee,
                       input int lat, input int rdo, input int wro,
                       input bit hold, input bit push, output int acc);
    int w;
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_funct3 = f3;
    bus.req_addr = a;
    bus.req_wdata = wd;
    w = 0;
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout addr=%h (cycle %0d)", a, cyc);
    end
    acc = cyc;
    if (push) sb.push_back('{er, ee, acc, lat, rdo, wro, {a[31:2], 2'b00}});
    @(negedge clk);
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] er);
    int acc;
    issue(1'b0, f3, a, 32'h0, er, 1'b0, 3, 1, -1, 1'b0, 1'b1, acc);
  endtask

  task automatic err_req(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int acc;
    issue(we, f3, a, 32'hCAFEF00D, 32'h0, 1'b1, 1, -1, -1, 1'b0, 1'b1, acc);
  endtask

  task automatic drain;
    int w;
    w = 0;
    while (sb.size() != 0 && w < 30) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout pending=%0d expected=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int acc, acc1, acc2;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    init_done = 1'b1;
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'h1);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
    chk("rst_mem_r_enable", {31'b0, bus.mem_r_enable}, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Load extension from 0x80FF7F01 at 0x100
    ld(3'b000, 32'h103, 32'hFFFFFF80);
    ld(3'b100, 32'h103, 32'h00000080);
    ld(3'b001, 32'h102, 32'hFFFF80FF);
    ld(3'b101, 32'h100, 32'h00007F01);
    ld(3'b010, 32'h100, 32'h80FF7F01);
    ld(3'b000, 32'h101, 32'h0000007F);
    ld(3'b001, 32'h100, 32'h00007F01);

    // Sub-word read-modify-write stores
    issue(1'b1, 3'b000, 32'h101, 32'hFFFFFFAB, 32'h0, 1'b0, 4, 1, 3, 1'b0, 1'b1, acc);
    issue(1'b1, 3'b001, 32'h102, 32'hABCD1234, 32'h0, 1'b0, 4, 1, 3, 1'b0, 1'b1, acc);
    ld(3'b010, 32'h100, 32'h1234AB01);

    // Full-word store
    issue(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 1'b0, 2, -1, 1, 1'b0, 1'b1, acc);
    ld(3'b010, 32'h104, 32'hDEADBEEF);

    // Errors never touch memory
    err_req(1'b0, 3'b010, 32'h102);
    err_req(1'b1, 3'b001, 32'h101);
    err_req(1'b0, 3'b011, 32'h100);
    err_req(1'b1, 3'b100, 32'h100);
    err_req(1'b0, 3'b101, 32'h103);
    ld(3'b010, 32'h100, 32'h1234AB01);
    drain();

    // Reset while an SB sits in CAP
    issue(1'b1, 3'b000, 32'h100, 32'h00000055, 32'h0, 1'b0, 4, 1, 3, 1'b0, 1'b0, acc);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_ready", {31'b0, bus.req_ready}, 32'h1);
    chk("arst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
    chk("arst_resp_err", {31'b0, bus.resp_err}, 32'h0);
    chk("arst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("arst_mem_r_enable", {31'b0, bus.mem_r_enable}, 32'h0);
    chk("arst_mem_w_enable", {31'b0, bus.mem_w_enable}, 32'h0);
    chk("arst_mem_addr", bus.mem_addr, 32'h0);
    chk("arst_mem_wdata", bus.mem_wdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", {31'b0, bus.req_ready}, 32'h1);
    repeat (4) @(negedge clk);
    chk("abort_no_write", wr_n, 0);
    chk("abort_mem_word", mem[8'h40], 32'h1234AB01);
    ld(3'b010, 32'h100, 32'h1234AB01);

    // Back-to-back with req_valid held high: LW then SB
    issue(1'b0, 3'b010, 32'h104, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1, -1, 1'b1, 1'b1, acc1);
    issue(1'b1, 3'b000, 32'h107, 32'h00000077, 32'h0, 1'b0, 4, 1, 3, 1'b0, 1'b1, acc2);
    chk("b2b_accept_cycle", acc2, acc1 + 4);
    ld(3'b010, 32'h104, 32'h77ADBEEF);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
